mux_rr_sched: RTL and testbench
===============================

MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one grant may be held (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] is requester i asking for the shared 4:1 data path.
REQ-005 The block SHALL have port I, input, 4 bits: I[i] is the data bit of requester i.
REQ-006 The block SHALL have port ack, input, 1 bit: the consumer has taken the current transfer and releases the grant.
REQ-007 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, all-zero when idle.
REQ-008 The block SHALL have port S, output, 2 bits: registered mux select, equal to the index of the granted requester.
REQ-009 The block SHALL have port valid, output, 1 bit: registered; high while a grant is active.
REQ-010 The block SHALL have port Y, output, 1 bit: combinational, Y = valid AND I[S].

Function
REQ-011 The block SHALL implement a two-state machine, IDLE and GRANT.
REQ-012 In IDLE with req nonzero, the block SHALL choose the first requester with req set, searching from (last+1) mod 4 upward and wrapping, and SHALL enter GRANT on the next edge.
REQ-013 On entering GRANT, the block SHALL set gnt to the one-hot of the chosen index, set S to that index, and set valid to 1, all registered; request-to-grant latency is 1 cycle.
REQ-014 In IDLE with req zero, the block SHALL stay in IDLE with gnt=0 and valid=0; S and last SHALL hold.
REQ-015 In GRANT, a release SHALL occur when any of these is true in a cycle: ack=1, req[S]=0, or the hold counter equals MAX_HOLD-1.
REQ-016 On release, the block SHALL return to IDLE on the next edge, clear gnt and valid, and set last to S.
REQ-017 After each release the block SHALL spend exactly one IDLE cycle before the next grant; there is no back-to-back grant.
REQ-018 The hold counter SHALL be 8 bits, SHALL clear on entering GRANT, SHALL increment each GRANT cycle without a release, and SHALL never wrap.
REQ-019 With MAX_HOLD=1, every grant SHALL last exactly one cycle.
REQ-020 Changes to req[j] for j not equal to S during GRANT SHALL NOT affect gnt, S or valid.
REQ-021 When ack and a req[S] drop occur in the same cycle, the block SHALL perform a single release identical to REQ-016.
REQ-022 gnt SHALL always be zero or one-hot, and gnt SHALL be nonzero if and only if valid=1.
REQ-023 Round-robin order SHALL guarantee that a continuously asserting requester is granted within 4 grants.

Reset
REQ-024 While rst_n=0, independent of clk, the block SHALL force state=IDLE, gnt=0, S=0, valid=0, hold counter=0 and last=3, so that requester 0 has first priority.
REQ-025 When reset is asserted during GRANT, the outputs SHALL clear immediately, Y SHALL be 0, and arbitration SHALL restart from REQ-024 values after rst_n rises.

Verification
REQ-026 The bench SHALL check this case: after reset, req=4'b1111 held, ack=0, MAX_HOLD=8 -> grants go to 0,1,2,3,0, each lasting 8 cycles, separated by 1 idle cycle.
REQ-027 The bench SHALL check this case: req=4'b0100, I=4'b0100 -> one cycle later gnt=4'b0100, S=2, valid=1, Y=1; then ack=1 for 1 cycle -> gnt=0 on the next edge.
REQ-028 The bench SHALL check this case: while granted to 1, req[1] drops and req[3] rises -> release, 1 idle cycle, then gnt=4'b1000.
REQ-029 The bench SHALL check this case: last=2, req=4'b0011 -> grant to 0 (wrap past 3), and the next grant goes to 1.
REQ-030 The bench SHALL check this case: rst_n pulsed low mid-grant between clock edges -> gnt, valid and Y go to 0 without a clock edge, and the first grant after reset with req=4'b1010 goes to 1.
REQ-031 The bench SHALL check this case: MAX_HOLD=1, req=4'b0001 held -> gnt toggles 0001,0000,0001,0000 every cycle.

Source files
------------

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin arbiter for four requesters sharing one 4:1 data path.
// A grant is held until the consumer acks, the owner drops its request, or the
// hold limit is reached. One idle cycle always separates two grants.
//
// state | meaning
// IDLE  | no owner; pick the next requester after 'last' and grant on the next edge
// GRANT | owner in r_sel drives Y; watch for ack, request drop or hold limit
module mux_rr_sched #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] I,
  input  logic       ack,
  output logic [3:0] gnt,
  output logic [1:0] S,
  output logic       valid,
  output logic       Y
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold count at which the current grant is forced to release.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_valid;
  logic [7:0] r_hold;
  logic [1:0] r_last;

  logic [1:0] w_pick;
  logic       w_found;
  logic [1:0] w_cand;
  logic       w_release;

  // Round-robin search: first set request starting one past the last owner, wrapping.
  always_comb begin
    w_pick  = 2'd0;
    w_found = 1'b0;
    w_cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + k[1:0];
      if (!w_found && req[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // Any one of the three release causes ends the grant; simultaneous causes give one release.
  always_comb begin
    w_release = ack | ~req[r_sel] | (r_hold == HOLD_LAST);
  end

  // Arbitration state machine with registered grant, select and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_hold  <= 8'd0;
      r_last  <= 2'd3;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_gnt   <= 4'b0001 << w_pick;
            r_sel   <= w_pick;
            r_valid <= 1'b1;
            r_hold  <= 8'd0;
          end else begin
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
            r_last  <= r_sel;
          end else if (r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign S     = r_sel;
  assign valid = r_valid;
  assign Y     = r_valid & I[r_sel];

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: stimulus pushes expected grants (owner, length, idle gap)
// into a queue; a monitor on the falling edge pops and checks each grant it sees.
module tb_mux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] I = 4'b0000;
  logic       ack = 1'b0;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       valid;
  logic       Y;

  logic [3:0] req_b = 4'b0000;
  logic [3:0] I_b = 4'b0001;
  logic       ack_b = 1'b0;
  logic [3:0] gnt_b;
  logic [1:0] S_b;
  logic       valid_b;
  logic       Y_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int len;  // -1: length not checked
    int gap;  // -1: preceding idle gap not checked
  } exp_t;

  exp_t sb[$];

  mux_rr_sched #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .I(I), .ack(ack),
    .gnt(gnt), .S(S), .valid(valid), .Y(Y)
  );

  mux_rr_sched #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .I(I_b), .ack(ack_b),
    .gnt(gnt_b), .S(S_b), .valid(valid_b), .Y(Y_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input int len, input int gap);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Monitor: per-cycle invariants plus grant start/end scoreboard checks.
  logic prev_valid = 1'b0;
  int   hi_cnt = 0;
  int   low_cnt = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (valid) begin
      chk("gnt_onehot_of_S", int'(gnt), int'(4'b0001 << S));
    end else begin
      chk("gnt_zero_idle", int'(gnt), 0);
    end
    chk("Y_mux", int'(Y), int'(valid & I[S]));
    if (valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant_idx", int'(S), -1);
        cur.idx = -1; cur.len = -1; cur.gap = -1;
      end else begin
        cur = sb.pop_front();
        chk("grant_S", int'(S), cur.idx);
        chk("grant_gnt", int'(gnt), 1 << cur.idx);
        if (cur.gap >= 0) chk("idle_gap", low_cnt, cur.gap);
      end
      hi_cnt = 1;
    end else if (valid) begin
      hi_cnt++;
    end else if (prev_valid) begin
      if (cur.len >= 0) chk("grant_len", hi_cnt, cur.len);
      low_cnt = 1;
    end else begin
      low_cnt++;
    end
    prev_valid = valid;
  end

  initial begin
    logic [3:0] exp_b_gnt [4];
    exp_b_gnt[0] = 4'b0001;
    exp_b_gnt[1] = 4'b0000;
    exp_b_gnt[2] = 4'b0001;
    exp_b_gnt[3] = 4'b0000;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_S", int'(S), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_Y", int'(Y), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // All four requesting: 0,1,2,3,0, 8 cycles each, 1 idle cycle between
    @(posedge clk); #1;
    push_exp(0, 8, -1);
    push_exp(1, 8, 1);
    push_exp(2, 8, 1);
    push_exp(3, 8, 1);
    push_exp(0, 8, 1);
    req = 4'b1111;
    repeat (45) @(posedge clk);
    #1 req = 4'b0000;
    repeat (3) @(posedge clk);

    // Single requester 2 with data, ack releases after one cycle
    #1;
    push_exp(2, 1, -1);
    req = 4'b0100;
    I   = 4'b0100;
    @(posedge clk); #1;
    chk("r2_gnt", int'(gnt), 4);
    chk("r2_S", int'(S), 2);
    chk("r2_valid", int'(valid), 1);
    chk("r2_Y", int'(Y), 1);
    ack = 1'b1;
    @(posedge clk); #1;
    chk("r2_gnt_after_ack", int'(gnt), 0);
    ack = 1'b0;
    req = 4'b0000;
    repeat (2) @(posedge clk);

    // Owner 1 drops while 3 rises; then ack and drop together release 3
    #1;
    push_exp(1, 2, -1);
    push_exp(3, 2, 1);
    req = 4'b0010;
    @(posedge clk);
    @(posedge clk); #1;
    req = 4'b1000;
    @(posedge clk); #1;
    chk("drop_release_gnt", int'(gnt), 0);
    @(posedge clk);
    @(posedge clk); #1;
    ack = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1;
    ack = 1'b0;
    repeat (2) @(posedge clk);

    // Make last=2, then req=0011 wraps to 0 then 1; a non-owner toggles mid-grant
    #1;
    push_exp(2, 1, -1);
    push_exp(0, 8, 1);
    push_exp(1, 8, 1);
    req = 4'b0100;
    @(posedge clk); #1;
    ack = 1'b1;
    req = 4'b0011;
    @(posedge clk); #1;
    ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 req = 4'b0111;
    repeat (2) @(posedge clk);
    #1 req = 4'b0011;
    repeat (13) @(posedge clk);
    #1 req = 4'b0000;
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-grant, then arbitration restarts with requester 0 first
    #1;
    push_exp(2, -1, -1);
    push_exp(1, 1, -1);
    req = 4'b0100;
    I   = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", int'(valid), 1);
    chk("pre_rst_Y", int'(Y), 1);
    #2 rst_n = 1'b0;
    req = 4'b1010;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_Y", int'(Y), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_gnt", int'(gnt), 2);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    req = 4'b0000;
    repeat (3) @(posedge clk);

    // MAX_HOLD=1 instance: grant toggles every cycle
    #1 req_b = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("mh1_gnt", int'(gnt_b), int'(exp_b_gnt[c]));
      chk("mh1_valid", int'(valid_b), int'(exp_b_gnt[c][0]));
      chk("mh1_Y", int'(Y_b), int'(exp_b_gnt[c][0]));
      chk("mh1_S", int'(S_b), 0);
    end
    req_b = 4'b0000;
    repeat (3) @(posedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
